// File: rtl/div_pkg.sv
// Shared types, default widths and configuration check for the iterative restoring divider.
package div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

  localparam int DW_DEF    = 72;
  localparam int MW_DEF    = 10;
  localparam int STEPS_DEF = 1;
  localparam int TW_DEF    = 8;

  // True when DW splits evenly into STEPS-wide slices and the divisor is narrower than the dividend.
  function automatic bit div_cfg_ok(input int dw, input int mw, input int steps);
    bit steps_ok;
    steps_ok = (steps == 32'sd1) || (steps == 32'sd2) || (steps == 32'sd4) || (steps == 32'sd8);
    return steps_ok && ((dw % steps) == 32'sd0) && (mw < dw);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {A,Q} left, trial-subtract M, keep or restore.
module div_step #(
  parameter int DW = 72,
  parameter int MW = 10
) (
  input  logic [MW:0]   a,
  input  logic [DW-1:0] q,
  input  logic [MW-1:0] m,
  output logic [MW:0]   a_next,
  output logic [DW-1:0] q_next
);

  logic [MW:0] shift_a_s;
  logic [MW:0] diff_s;
  logic        borrow_s;

  assign shift_a_s = {a[MW-1:0], q[DW-1]};
  assign diff_s    = shift_a_s - {1'b0, m};
  // A set bit shifted out of A means the partial remainder already exceeds M, so no borrow.
  assign borrow_s  = diff_s[MW] & ~a[MW];
  assign a_next    = borrow_s ? shift_a_s : diff_s;
  assign q_next    = {q[DW-2:0], ~borrow_s};

endmodule

// File: rtl/divide_iter_unit.sv
// Iterative unsigned restoring divider retiring STEPS quotient bits per clock, with tag pass-through
// and divide-by-zero short-circuit.
module divide_iter_unit
  import div_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int MW    = MW_DEF,
  parameter int STEPS = STEPS_DEF,
  parameter int TW    = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pushin,
  output logic          ready,
  input  logic [DW-1:0] dividend_in,
  input  logic [MW-1:0] divisor_in,
  input  logic [TW-1:0] tag_in,
  output logic          pushout,
  output logic [DW-1:0] quotient_out,
  output logic [MW-1:0] remainder_out,
  output logic [TW-1:0] tag_out,
  output logic          div_zero
);

  localparam int NCYC = DW / STEPS;
  localparam int CW   = $clog2(NCYC + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NCYC);

  if (!div_cfg_ok(DW, MW, STEPS)) begin : g_cfg_check
    $error("divide_iter_unit: illegal DW/MW/STEPS combination");
  end

  div_state_e    state_r, state_nxt_s;
  logic [MW:0]   a_r;
  logic [DW-1:0] q_r;
  logic [MW-1:0] m_r;
  logic [TW-1:0] tag_r;
  logic [CW-1:0] cnt_r;
  logic          start_s, zero_s, done_s;
  logic [MW:0]   a_fin_s;
  logic [DW-1:0] q_fin_s;

  logic          pushout_r, div_zero_r;
  logic [DW-1:0] quotient_r;
  logic [MW-1:0] remainder_r;
  logic [TW-1:0] tag_out_r;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic [MW:0]   a_src_s, a_res_s;
    logic [DW-1:0] q_src_s, q_res_s;
    if (i == 0) begin : g_first
      assign a_src_s = a_r;
      assign q_src_s = q_r;
    end else begin : g_chain
      assign a_src_s = g_step[i-1].a_res_s;
      assign q_src_s = g_step[i-1].q_res_s;
    end
    div_step #(.DW(DW), .MW(MW)) u_step (
      .a      (a_src_s),
      .q      (q_src_s),
      .m      (m_r),
      .a_next (a_res_s),
      .q_next (q_res_s)
    );
  end

  assign a_fin_s = g_step[STEPS-1].a_res_s;
  assign q_fin_s = g_step[STEPS-1].q_res_s;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    zero_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pushin && (divisor_in == {MW{1'b0}})) begin
          zero_s = 1'b1;
        end else if (pushin) begin
          start_s     = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_ONE) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand, iteration counter and tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {(MW+1){1'b0}};
      q_r   <= {DW{1'b0}};
      m_r   <= {MW{1'b0}};
      tag_r <= {TW{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (start_s) begin
      a_r   <= {(MW+1){1'b0}};
      q_r   <= dividend_in;
      m_r   <= divisor_in;
      tag_r <= tag_in;
      cnt_r <= CNT_LOAD;
    end else if (state_r == RUN) begin
      a_r   <= a_fin_s;
      q_r   <= q_fin_s;
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // Result registers; pushout pulses for one cycle and results hold until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      pushout_r   <= 1'b0;
      div_zero_r  <= 1'b0;
      quotient_r  <= {DW{1'b0}};
      remainder_r <= {MW{1'b0}};
      tag_out_r   <= {TW{1'b0}};
    end else if (zero_s) begin
      pushout_r   <= 1'b1;
      div_zero_r  <= 1'b1;
      quotient_r  <= {DW{1'b1}};
      remainder_r <= dividend_in[MW-1:0];
      tag_out_r   <= tag_in;
    end else if (done_s) begin
      pushout_r   <= 1'b1;
      div_zero_r  <= 1'b0;
      quotient_r  <= q_fin_s;
      remainder_r <= a_fin_s[MW-1:0];
      tag_out_r   <= tag_r;
    end else begin
      pushout_r   <= 1'b0;
    end
  end

  assign ready         = (state_r == IDLE);
  assign pushout       = pushout_r;
  assign div_zero      = div_zero_r;
  assign quotient_out  = quotient_r;
  assign remainder_out = remainder_r;
  assign tag_out       = tag_out_r;

endmodule

// File: tb/tb_divide_iter_unit.sv
// Scoreboard bench for divide_iter_unit: STEPS=1, 4 and 8 instances checked against a reference divider.
module tb_divide_iter_unit;

  localparam int DW = 72;
  localparam int MW = 10;
  localparam int TW = 8;
  localparam int NU = 3;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [MW-1:0] r;
    logic [TW-1:0] tag;
    logic          dz;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic          pin_v  [NU];
  logic          rdy_v  [NU];
  logic [DW-1:0] dvd_v  [NU];
  logic [MW-1:0] dvs_v  [NU];
  logic [TW-1:0] tagi_v [NU];
  logic          po_v   [NU];
  logic [DW-1:0] quot_v [NU];
  logic [MW-1:0] rem_v  [NU];
  logic [TW-1:0] tago_v [NU];
  logic          dz_v   [NU];

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    divide_iter_unit #(.DW(DW), .MW(MW), .STEPS(ST), .TW(TW)) dut (
      .clk           (clk),
      .rst           (rst),
      .pushin        (pin_v[g]),
      .ready         (rdy_v[g]),
      .dividend_in   (dvd_v[g]),
      .divisor_in    (dvs_v[g]),
      .tag_in        (tagi_v[g]),
      .pushout       (po_v[g]),
      .quotient_out  (quot_v[g]),
      .remainder_out (rem_v[g]),
      .tag_out       (tago_v[g]),
      .div_zero      (dz_v[g])
    );
  end

  function automatic int lat_of(input int u, input logic [MW-1:0] dvs);
    int st;
    st = (u == 0) ? 1 : ((u == 1) ? 4 : 8);
    return (dvs == '0) ? 0 : DW / st;
  endfunction

  function automatic res_t model(input logic [DW-1:0] dvd, input logic [MW-1:0] dvs,
                                 input logic [TW-1:0] tag);
    res_t          r;
    logic [DW-1:0] dvs_w;
    logic [DW-1:0] rem_w;
    dvs_w = {{(DW-MW){1'b0}}, dvs};
    if (dvs == '0) begin
      r.q  = '1;
      r.r  = dvd[MW-1:0];
      r.dz = 1'b1;
    end else begin
      r.q   = dvd / dvs_w;
      rem_w = dvd % dvs_w;
      r.r   = rem_w[MW-1:0];
      r.dz  = 1'b0;
    end
    r.tag = tag;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge and record its expected result.
  task automatic send(input int u, input logic [DW-1:0] dvd, input logic [MW-1:0] dvs,
                      input logic [TW-1:0] tag);
    dvd_v[u]  = dvd;
    dvs_v[u]  = dvs;
    tagi_v[u] = tag;
    pin_v[u]  = 1'b1;
    exp_q.push_back(model(dvd, dvs, tag));
    tick();
    pin_v[u]  = 1'b0;
  endtask

  task automatic wait_pushout(input int u, input int budget, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n <= budget) begin
      if (po_v[u] === 1'b1) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      checks++;
      if ({rdy_v[u], po_v[u], dz_v[u], quot_v[u], rem_v[u], tago_v[u]} !==
          {1'b1, 1'b0, 1'b0, {DW{1'b0}}, {MW{1'b0}}, {TW{1'b0}}}) begin
        failures++;
        $display("FAIL reset_state u=%0d ready=%b pushout=%b dz=%b q=%h r=%h tag=%h, required ready=1 rest 0",
                 u, rdy_v[u], po_v[u], dz_v[u], quot_v[u], rem_v[u], tago_v[u]);
      end
    end
  endtask

  task automatic test_basic();
    int n; bit seen; res_t got, e;
    send(0, 72'd1000, 10'd7, 8'h3C);
    wait_pushout(0, 200, n, seen);
    checks++;
    if (!seen || n != 72) begin
      failures++;
      $display("FAIL basic_latency seen=%b got=%0d required=72", seen, n);
    end
    e   = exp_q.pop_front();
    got = {quot_v[0], rem_v[0], tago_v[0], dz_v[0]};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL basic_result got=%h required=%h", got, e);
    end
    checks++;
    if (quot_v[0] !== 72'd142 || rem_v[0] !== 10'd6) begin
      failures++;
      $display("FAIL basic_const q=%0d r=%0d required q=142 r=6", quot_v[0], rem_v[0]);
    end
    tick();
    checks++;
    if (po_v[0] !== 1'b0 || quot_v[0] !== e.q || rdy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_pulse pushout=%b q=%0d ready=%b required pushout=0 q=%0d ready=1",
               po_v[0], quot_v[0], rdy_v[0], e.q);
    end
  endtask

  task automatic test_zero();
    int n; bit seen; res_t got, e;
    send(0, 72'h12345, 10'd0, 8'h5A);
    wait_pushout(0, 5, n, seen);
    checks++;
    if (!seen || n != 0 || rdy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL zero_latency seen=%b extra=%0d ready=%b required pushout in next cycle, ready=1",
               seen, n, rdy_v[0]);
    end
    e   = exp_q.pop_front();
    got = {quot_v[0], rem_v[0], tago_v[0], dz_v[0]};
    checks++;
    if (got !== e || rem_v[0] !== 10'h345 || dz_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL zero_result got=%h required=%h", got, e);
    end
    tick();
    checks++;
    if (po_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse pushout=%b required 0", po_v[0]);
    end
  endtask

  task automatic test_boundary();
    int n; bit seen; res_t got, e;
    logic [DW-1:0] dvds [2];
    dvds[0] = {DW{1'b1}};
    dvds[1] = 72'd5;
    for (int i = 0; i < 2; i++) begin
      send(0, dvds[i], 10'd1023, 8'(i + 16));
      wait_pushout(0, 200, n, seen);
      e   = exp_q.pop_front();
      got = {quot_v[0], rem_v[0], tago_v[0], dz_v[0]};
      checks++;
      if (!seen || got !== e) begin
        failures++;
        $display("FAIL boundary_%0d seen=%b got=%h required=%h", i, seen, got, e);
      end
    end
    checks++;
    if (rem_v[0] !== 10'd5 || quot_v[0] !== 72'd0) begin
      failures++;
      $display("FAIL boundary_small q=%0d r=%0d required q=0 r=5", quot_v[0], rem_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2; bit s1, s2; res_t got, e;
    dvd_v[0] = 72'd100; dvs_v[0] = 10'd10; tagi_v[0] = 8'h01; pin_v[0] = 1'b1;
    exp_q.push_back(model(72'd100, 10'd10, 8'h01));
    exp_q.push_back(model(72'd99, 10'd10, 8'h02));
    tick();
    dvd_v[0] = 72'd99; tagi_v[0] = 8'h02;
    wait_pushout(0, 200, n1, s1);
    e   = exp_q.pop_front();
    got = {quot_v[0], rem_v[0], tago_v[0], dz_v[0]};
    checks++;
    if (!s1 || n1 != 72 || got !== e || rdy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first seen=%b lat=%0d ready=%b got=%h required lat=72 ready=1 %h",
               s1, n1, rdy_v[0], got, e);
    end
    tick();
    pin_v[0] = 1'b0;
    wait_pushout(0, 200, n2, s2);
    e   = exp_q.pop_front();
    got = {quot_v[0], rem_v[0], tago_v[0], dz_v[0]};
    checks++;
    if (!s2 || (n2 + 1) != 73 || got !== e) begin
      failures++;
      $display("FAIL b2b_second seen=%b spacing=%0d got=%h required spacing=73 %h",
               s2, n2 + 1, got, e);
    end
  endtask

  task automatic test_ignore_pushin();
    int n; bit seen; res_t got, e; int extra;
    send(0, 72'd500, 10'd3, 8'h11);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (rdy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL ignore_ready ready=%b required 0", rdy_v[0]);
    end
    dvd_v[0] = 72'd777; dvs_v[0] = 10'd0; tagi_v[0] = 8'hEE; pin_v[0] = 1'b1;
    tick();
    pin_v[0] = 1'b0;
    wait_pushout(0, 200, n, seen);
    e   = exp_q.pop_front();
    got = {quot_v[0], rem_v[0], tago_v[0], dz_v[0]};
    checks++;
    if (!seen || (n + 11) != 72 || got !== e) begin
      failures++;
      $display("FAIL ignore_result seen=%b lat=%0d got=%h required lat=72 %h", seen, n + 11, got, e);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (po_v[0] === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignore_extra pushouts=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    send(0, 72'd1000, 10'd7, 8'h77);
    void'(exp_q.pop_back());
    for (int i = 0; i < 29; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({rdy_v[0], po_v[0], dz_v[0], quot_v[0], rem_v[0], tago_v[0]} !==
        {1'b1, 1'b0, 1'b0, {DW{1'b0}}, {MW{1'b0}}, {TW{1'b0}}}) begin
      failures++;
      $display("FAIL midrun_reset ready=%b pushout=%b q=%h r=%h tag=%h required ready=1 rest 0",
               rdy_v[0], po_v[0], quot_v[0], rem_v[0], tago_v[0]);
    end
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (po_v[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL midrun_no_pushout pushouts=%0d required 0", pulses);
    end
  endtask

  task automatic test_random(input int u, input int count);
    int n; bit seen; res_t got, e;
    logic [95:0] raw;
    logic [MW-1:0] dvs;
    int mode;
    for (int k = 0; k < count; k++) begin
      raw  = {$urandom(), $urandom(), $urandom()};
      mode = $urandom_range(0, 9);
      case (mode)
        0: dvs = 10'd0;
        1: dvs = 10'd1023;
        2: dvs = 10'd1;
        default: dvs = MW'($urandom());
      endcase
      if (mode == 3) raw[95:8] = '0;
      send(u, raw[DW-1:0], dvs, TW'($urandom()));
      wait_pushout(u, 200, n, seen);
      e   = exp_q.pop_front();
      got = {quot_v[u], rem_v[u], tago_v[u], dz_v[u]};
      checks++;
      if (!seen || n != lat_of(u, dvs) || got !== e) begin
        failures++;
        $display("FAIL random_u%0d_%0d seen=%b lat=%0d got=%h required lat=%0d %h",
                 u, k, seen, n, got, lat_of(u, dvs), e);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      pin_v[u] = 1'b0; dvd_v[u] = '0; dvs_v[u] = '0; tagi_v[u] = '0;
    end
    test_reset();
    test_basic();
    test_zero();
    test_boundary();
    test_back_to_back();
    test_ignore_pushin();
    test_reset_mid_run();
    test_random(0, 15);
    test_random(1, 150);
    test_random(2, 150);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
